pipe_stage_skid_reg: RTL and testbench

//   Parametrised elastic pipeline-stage register; successor to the fixed IF/ID latch.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_slot.sv | 44 ++++
 rtl/pipe_stage_skid_reg.sv | 133 +++++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline-stage registers: default widths,
// the NOP bubble encoding and the stage-occupancy state type.
package pipe_pkg;

    localparam int unsigned PC_W_DEF   = 32;
    localparam int unsigned INST_W_DEF = 32;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } occ_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of an elastic stage: valid flag plus {PC, instruction}.
// The instruction output reads as the NOP bubble whenever the slot is empty.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned       PC_W     = PC_W_DEF,
    parameter int unsigned       INST_W   = INST_W_DEF,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(pipe_pkg::NOP_INST)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [PC_W-1:0]   i_pc,
    input  logic [INST_W-1:0] i_inst,
    output logic              o_valid,
    output logic [PC_W-1:0]   o_pc,
    output logic [INST_W-1:0] o_inst
);

    logic              r_valid;
    logic [PC_W-1:0]   r_pc;
    logic [INST_W-1:0] r_inst;

    // Clear only drops valid; PC keeps its last value for visibility.
    always_ff @(negedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_inst  <= NOP_INST;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_inst  <= i_inst;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_inst  = r_valid ? r_inst : NOP_INST;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Elastic {PC, instruction} pipeline register with a 2-entry skid buffer,
// registered upstream ready and flush-to-bubble. State updates on negedge clk_PR.
module pipe_stage_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       PC_W     = PC_W_DEF,
    parameter int unsigned       INST_W   = INST_W_DEF,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(pipe_pkg::NOP_INST)
) (
    input  logic              clk_PR,
    input  logic              rst_PR,
    input  logic              flush_PR,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [PC_W-1:0]   PC_in,
    input  logic [INST_W-1:0] inst_in,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [PC_W-1:0]   PC_out,
    output logic [INST_W-1:0] inst_out
);

    occ_e r_state;
    occ_e w_next;

    logic              w_push;
    logic              w_pop;
    logic              w_main_load;
    logic              w_main_clear;
    logic              w_main_from_skid;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic              w_main_valid;
    logic              w_skid_valid;
    logic [PC_W-1:0]   w_skid_pc;
    logic [INST_W-1:0] w_skid_inst;
    logic [PC_W-1:0]   w_main_pc_d;
    logic [INST_W-1:0] w_main_inst_d;

    assign ready_out = ~w_skid_valid;
    assign w_push    = valid_in & ready_out;
    assign w_pop     = w_main_valid & ready_in;

    always_ff @(negedge clk_PR) begin
        if (rst_PR) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        w_main_load      = 1'b0;
        w_main_clear     = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        if (flush_PR) begin
            w_next       = ST_EMPTY;
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_main_load = 1'b1;
                        w_next      = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        w_main_load = 1'b1;
                    end else if (w_push) begin
                        w_skid_load = 1'b1;
                        w_next      = ST_FULL;
                    end else if (w_pop) begin
                        w_main_clear = 1'b1;
                        w_next       = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // Oldest word lives in main, so a pop refills main from skid.
                    if (w_pop) begin
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_clear     = 1'b1;
                        w_next           = ST_ONE;
                    end
                end
                default: w_next = ST_EMPTY;
            endcase
        end
    end

    assign w_main_pc_d   = w_main_from_skid ? w_skid_pc   : PC_in;
    assign w_main_inst_d = w_main_from_skid ? w_skid_inst : inst_in;

    pipe_slot #(
        .PC_W     (PC_W),
        .INST_W   (INST_W),
        .NOP_INST (NOP_INST)
    ) u_main (
        .i_clk   (clk_PR),
        .i_rst   (rst_PR),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_pc    (w_main_pc_d),
        .i_inst  (w_main_inst_d),
        .o_valid (w_main_valid),
        .o_pc    (PC_out),
        .o_inst  (inst_out)
    );

    pipe_slot #(
        .PC_W     (PC_W),
        .INST_W   (INST_W),
        .NOP_INST (NOP_INST)
    ) u_skid (
        .i_clk   (clk_PR),
        .i_rst   (rst_PR),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_pc    (PC_in),
        .i_inst  (inst_in),
        .o_valid (w_skid_valid),
        .o_pc    (w_skid_pc),
        .o_inst  (w_skid_inst)
    );

    assign valid_out = w_main_valid;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg: inputs change after posedge, the DUT
// updates on negedge, outputs are sampled on the following posedge.
module tb_pipe_stage_skid_reg;

    logic        clk_PR = 1'b1;
    logic        rst_PR = 1'b0;
    logic        flush_PR = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic [31:0] PC_in = '0;
    logic [31:0] inst_in = '0;
    logic        valid_out;
    logic        ready_in = 1'b0;
    logic [31:0] PC_out;
    logic [31:0] inst_out;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ITAG = 32'hA000_0000;

    typedef struct {
        bit          rst;
        bit          flush;
        bit          vin;
        bit          rdy;
        logic [31:0] pc;
        bit          ev;
        logic [31:0] epc;
        bit          er;
    } vec_t;

    always #5 clk_PR = ~clk_PR;

    pipe_stage_skid_reg #(
        .PC_W     (32),
        .INST_W   (32),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk_PR    (clk_PR),
        .rst_PR    (rst_PR),
        .flush_PR  (flush_PR),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .PC_in     (PC_in),
        .inst_in   (inst_in),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .PC_out    (PC_out),
        .inst_out  (inst_out)
    );

    task automatic test_reset();
        vec_t v[3];
        logic [31:0] ei;
        v[0] = '{1, 0, 1, 1, 32'hDEAD_BEE0, 0, 32'h0, 1};
        v[1] = '{1, 0, 1, 1, 32'hDEAD_BEE4, 0, 32'h0, 1};
        v[2] = '{0, 0, 0, 1, 32'h0,         0, 32'h0, 1};
        for (int i = 0; i < 3; i++) begin
            rst_PR = v[i].rst; flush_PR = v[i].flush; valid_in = v[i].vin;
            ready_in = v[i].rdy; PC_in = v[i].pc; inst_in = ITAG | v[i].pc;
            @(negedge clk_PR); @(posedge clk_PR);
            ei = v[i].ev ? (ITAG | v[i].epc) : NOP;
            n_cmp += 4;
            if (valid_out !== v[i].ev) begin n_err++; $display("FAIL reset[%0d] valid_out got %b want %b", i, valid_out, v[i].ev); end
            if (PC_out !== v[i].epc) begin n_err++; $display("FAIL reset[%0d] PC_out got %h want %h", i, PC_out, v[i].epc); end
            if (inst_out !== ei) begin n_err++; $display("FAIL reset[%0d] inst_out got %h want %h", i, inst_out, ei); end
            if (ready_out !== v[i].er) begin n_err++; $display("FAIL reset[%0d] ready_out got %b want %b", i, ready_out, v[i].er); end
        end
    endtask

    task automatic test_stream();
        vec_t v[5];
        logic [31:0] ei;
        v[0] = '{0, 0, 1, 1, 32'h0, 1, 32'h0, 1};
        v[1] = '{0, 0, 1, 1, 32'h4, 1, 32'h4, 1};
        v[2] = '{0, 0, 1, 1, 32'h8, 1, 32'h8, 1};
        v[3] = '{0, 0, 1, 1, 32'hC, 1, 32'hC, 1};
        v[4] = '{0, 0, 0, 1, 32'h0, 0, 32'hC, 1};
        for (int i = 0; i < 5; i++) begin
            rst_PR = v[i].rst; flush_PR = v[i].flush; valid_in = v[i].vin;
            ready_in = v[i].rdy; PC_in = v[i].pc; inst_in = ITAG | v[i].pc;
            @(negedge clk_PR); @(posedge clk_PR);
            ei = v[i].ev ? (ITAG | v[i].epc) : NOP;
            n_cmp += 4;
            if (valid_out !== v[i].ev) begin n_err++; $display("FAIL stream[%0d] valid_out got %b want %b", i, valid_out, v[i].ev); end
            if (PC_out !== v[i].epc) begin n_err++; $display("FAIL stream[%0d] PC_out got %h want %h", i, PC_out, v[i].epc); end
            if (inst_out !== ei) begin n_err++; $display("FAIL stream[%0d] inst_out got %h want %h", i, inst_out, ei); end
            if (ready_out !== v[i].er) begin n_err++; $display("FAIL stream[%0d] ready_out got %b want %b", i, ready_out, v[i].er); end
        end
    endtask

    task automatic test_skid();
        vec_t v[6];
        logic [31:0] ei;
        v[0] = '{0, 0, 1, 1, 32'h10, 1, 32'h10, 1};
        v[1] = '{0, 0, 1, 1, 32'h14, 1, 32'h14, 1};
        v[2] = '{0, 0, 1, 0, 32'h18, 1, 32'h14, 0};
        v[3] = '{0, 0, 1, 1, 32'h1C, 1, 32'h18, 1};
        v[4] = '{0, 0, 1, 1, 32'h1C, 1, 32'h1C, 1};
        v[5] = '{0, 0, 0, 1, 32'h0,  0, 32'h1C, 1};
        for (int i = 0; i < 6; i++) begin
            rst_PR = v[i].rst; flush_PR = v[i].flush; valid_in = v[i].vin;
            ready_in = v[i].rdy; PC_in = v[i].pc; inst_in = ITAG | v[i].pc;
            @(negedge clk_PR); @(posedge clk_PR);
            ei = v[i].ev ? (ITAG | v[i].epc) : NOP;
            n_cmp += 4;
            if (valid_out !== v[i].ev) begin n_err++; $display("FAIL skid[%0d] valid_out got %b want %b", i, valid_out, v[i].ev); end
            if (PC_out !== v[i].epc) begin n_err++; $display("FAIL skid[%0d] PC_out got %h want %h", i, PC_out, v[i].epc); end
            if (inst_out !== ei) begin n_err++; $display("FAIL skid[%0d] inst_out got %h want %h", i, inst_out, ei); end
            if (ready_out !== v[i].er) begin n_err++; $display("FAIL skid[%0d] ready_out got %b want %b", i, ready_out, v[i].er); end
        end
    endtask

    task automatic test_long_stall();
        vec_t v[9];
        logic [31:0] ei;
        v[0] = '{0, 0, 1, 0, 32'h20, 1, 32'h20, 1};
        v[1] = '{0, 0, 1, 0, 32'h24, 1, 32'h20, 0};
        for (int k = 2; k < 7; k++) v[k] = '{0, 0, 1, 0, 32'h28, 1, 32'h20, 0};
        v[7] = '{0, 0, 0, 1, 32'h0, 1, 32'h24, 1};
        v[8] = '{0, 0, 0, 1, 32'h0, 0, 32'h24, 1};
        for (int i = 0; i < 9; i++) begin
            rst_PR = v[i].rst; flush_PR = v[i].flush; valid_in = v[i].vin;
            ready_in = v[i].rdy; PC_in = v[i].pc; inst_in = ITAG | v[i].pc;
            @(negedge clk_PR); @(posedge clk_PR);
            ei = v[i].ev ? (ITAG | v[i].epc) : NOP;
            n_cmp += 4;
            if (valid_out !== v[i].ev) begin n_err++; $display("FAIL stall[%0d] valid_out got %b want %b", i, valid_out, v[i].ev); end
            if (PC_out !== v[i].epc) begin n_err++; $display("FAIL stall[%0d] PC_out got %h want %h", i, PC_out, v[i].epc); end
            if (inst_out !== ei) begin n_err++; $display("FAIL stall[%0d] inst_out got %h want %h", i, inst_out, ei); end
            if (ready_out !== v[i].er) begin n_err++; $display("FAIL stall[%0d] ready_out got %b want %b", i, ready_out, v[i].er); end
        end
    endtask

    task automatic test_flush();
        vec_t v[6];
        logic [31:0] ei;
        v[0] = '{0, 0, 1, 0, 32'h30, 1, 32'h30, 1};
        v[1] = '{0, 0, 1, 0, 32'h34, 1, 32'h30, 0};
        v[2] = '{0, 1, 1, 0, 32'h38, 0, 32'h30, 1};
        v[3] = '{0, 0, 1, 1, 32'h40, 1, 32'h40, 1};
        v[4] = '{0, 0, 0, 1, 32'h0,  0, 32'h40, 1};
        v[5] = '{0, 0, 0, 1, 32'h0,  0, 32'h40, 1};
        for (int i = 0; i < 6; i++) begin
            rst_PR = v[i].rst; flush_PR = v[i].flush; valid_in = v[i].vin;
            ready_in = v[i].rdy; PC_in = v[i].pc; inst_in = ITAG | v[i].pc;
            @(negedge clk_PR); @(posedge clk_PR);
            ei = v[i].ev ? (ITAG | v[i].epc) : NOP;
            n_cmp += 4;
            if (valid_out !== v[i].ev) begin n_err++; $display("FAIL flush[%0d] valid_out got %b want %b", i, valid_out, v[i].ev); end
            if (PC_out !== v[i].epc) begin n_err++; $display("FAIL flush[%0d] PC_out got %h want %h", i, PC_out, v[i].epc); end
            if (inst_out !== ei) begin n_err++; $display("FAIL flush[%0d] inst_out got %h want %h", i, inst_out, ei); end
            if (ready_out !== v[i].er) begin n_err++; $display("FAIL flush[%0d] ready_out got %b want %b", i, ready_out, v[i].er); end
        end
    endtask

    task automatic test_reset_midstream();
        vec_t v[4];
        logic [31:0] ei;
        v[0] = '{0, 0, 1, 0, 32'h50, 1, 32'h50, 1};
        v[1] = '{0, 0, 1, 0, 32'h54, 1, 32'h50, 0};
        v[2] = '{1, 1, 1, 1, 32'h58, 0, 32'h0,  1};
        v[3] = '{0, 0, 0, 1, 32'h0,  0, 32'h0,  1};
        for (int i = 0; i < 4; i++) begin
            rst_PR = v[i].rst; flush_PR = v[i].flush; valid_in = v[i].vin;
            ready_in = v[i].rdy; PC_in = v[i].pc; inst_in = ITAG | v[i].pc;
            @(negedge clk_PR); @(posedge clk_PR);
            ei = v[i].ev ? (ITAG | v[i].epc) : NOP;
            n_cmp += 4;
            if (valid_out !== v[i].ev) begin n_err++; $display("FAIL rstmid[%0d] valid_out got %b want %b", i, valid_out, v[i].ev); end
            if (PC_out !== v[i].epc) begin n_err++; $display("FAIL rstmid[%0d] PC_out got %h want %h", i, PC_out, v[i].epc); end
            if (inst_out !== ei) begin n_err++; $display("FAIL rstmid[%0d] inst_out got %h want %h", i, inst_out, ei); end
            if (ready_out !== v[i].er) begin n_err++; $display("FAIL rstmid[%0d] ready_out got %b want %b", i, ready_out, v[i].er); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_long_stall();
        test_flush();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
